// File: rtl/imm_gen_pkg.sv
// Shared constants for the RV64I immediate generator.
// Opcodes and immediate format codes.
package imm_gen_pkg;

  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] FENCE     = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  function automatic logic is_shift(
    input logic [2:0] f3
  );
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction.
// Keyed on opcode, plus funct3 for shifts.
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [63:0] imm,
  output logic [2:0]  fmt,
  output logic        illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [63:0] sx;

  assign opc = instruction[6:0];
  assign f3  = instruction[14:12];
  assign sx  = {64{instruction[31]}};

  // Select field layout from the opcode
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OP_IMM: begin
        if (is_shift(f3)) begin
          imm = {58'd0, instruction[25:20]};
          fmt = FMT_SHAMT;
        end else begin
          imm = {sx[63:12], instruction[31:20]};
          fmt = FMT_I;
        end
      end
      OP_IMM_32: begin
        if (is_shift(f3)) begin
          imm = {59'd0, instruction[24:20]};
          fmt = FMT_SHAMT;
        end else begin
          imm = {sx[63:12], instruction[31:20]};
          fmt = FMT_I;
        end
      end
      LOAD, JALR, SYSTEM: begin
        imm = {sx[63:12], instruction[31:20]};
        fmt = FMT_I;
      end
      STORE: begin
        imm = {sx[63:12], instruction[31:25],
               instruction[11:7]};
        fmt = FMT_S;
      end
      BRANCH: begin
        imm = {sx[63:13], instruction[31],
               instruction[7], instruction[30:25],
               instruction[11:8], 1'b0};
        fmt = FMT_B;
      end
      LUI, AUIPC: begin
        imm = {sx[63:32], instruction[31:12],
               12'd0};
        fmt = FMT_U;
      end
      JAL: begin
        imm = {sx[63:21], instruction[31],
               instruction[19:12], instruction[20],
               instruction[30:21], 1'b0};
        fmt = FMT_J;
      end
      OP, OP_32, FENCE: begin
        imm = '0;
        fmt = FMT_NONE;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// Registered RV64I immediate generator.
// One-cycle latency, no backpressure.
module imm_gen
  import imm_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instruction,
  output logic        out_valid,
  output logic [63:0] imm,
  output logic [2:0]  fmt,
  output logic        illegal
);

  logic [63:0] d_imm;
  logic [2:0]  d_fmt;
  logic        d_ill;

  imm_decode u_dec (
    .instruction (instruction),
    .imm         (d_imm),
    .fmt         (d_fmt),
    .illegal     (d_ill)
  );

  // Capture decode on valid; hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      imm       <= '0;
      fmt       <= FMT_NONE;
      illegal   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        imm     <= d_imm;
        fmt     <= d_fmt;
        illegal <= d_ill;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen.sv
// Directed testbench for imm_gen.
// Hand-computed vectors, assertion checks.
module tb_imm_gen;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_valid;
  logic [63:0] imm;
  logic [2:0]  fmt;
  logic        illegal;

  int compared = 0;
  int mismatched = 0;

  imm_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .instruction (instruction),
    .out_valid   (out_valid),
    .imm         (imm),
    .fmt         (fmt),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v,
                      input logic [31:0] w);
    @(negedge clk);
    in_valid = v;
    instruction = w;
    @(posedge clk);
    #1;
  endtask

  task automatic res(input string tag,
                     input logic ov,
                     input logic [63:0] ei,
                     input logic [2:0] ef,
                     input logic el);
    chk({tag, ".vld"}, {63'd0, out_valid}, {63'd0, ov});
    chk({tag, ".imm"}, imm, ei);
    chk({tag, ".fmt"}, {61'd0, fmt}, {61'd0, ef});
    chk({tag, ".ill"}, {63'd0, illegal}, {63'd0, el});
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    instruction = 32'd0;
    step(1'b0, 32'd0);
    step(1'b1, 32'h00500093);
    res("rst0", 1'b0, 64'd0, 3'd0, 1'b0);
    rst_n = 1'b1;

    step(1'b1, 32'h00500093);
    res("addi5", 1'b1, 64'h5, 3'd1, 1'b0);
    step(1'b1, 32'hFFF00093);
    res("addim1", 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    step(1'b1, 32'hFE000CE3);
    res("beq", 1'b1, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    step(1'b1, 32'h800000B7);
    res("lui", 1'b1, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    step(1'b1, 32'h0080006F);
    res("jal", 1'b1, 64'h8, 3'd5, 1'b0);
    step(1'b1, 32'hFE112E23);
    res("sw", 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    step(1'b1, 32'h03F09093);
    res("slli", 1'b1, 64'h3F, 3'd6, 1'b0);
    step(1'b1, 32'h4030D093);
    res("srai", 1'b1, 64'h3, 3'd6, 1'b0);
    step(1'b1, 32'h03F0909B);
    res("slliw", 1'b1, 64'h1F, 3'd6, 1'b0);
    step(1'b1, 32'h12345017);
    res("auipc", 1'b1, 64'h12345000, 3'd4, 1'b0);
    step(1'b1, 32'h80003083);
    res("ld", 1'b1, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0);
    step(1'b1, 32'h002081B3);
    res("add", 1'b1, 64'd0, 3'd0, 1'b0);
    step(1'b1, 32'h0000007F);
    res("bad", 1'b1, 64'd0, 3'd0, 1'b1);

    step(1'b1, 32'hFFF00093);
    res("pre", 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    step(1'b0, 32'h0080006F);
    res("hold", 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);

    rst_n = 1'b0;
    step(1'b1, 32'h800000B7);
    res("rstv", 1'b0, 64'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 32'h0080006F);
    res("post", 1'b1, 64'h8, 3'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
